// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the x0 constant and the write-request payload for the register-file
// writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned SEC_DEPTH      = 4;
    localparam int unsigned SEC_STARVE_MAX = 8;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO for queued secondary writebacks; same-cycle push and pop allowed,
// push ignored while full, pop ignored while empty.
module wb_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    // Storage is data-only and needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write-port driver for the register file: primary writeback wins, queued
// secondary results drain in idle primary cycles, starvation raises drain_req.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = SEC_DEPTH,
    parameter int unsigned STARVE_MAX = SEC_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_valid,
    input  logic [REG_ADDR_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    sec_valid,
    output logic                    sec_ready,
    input  logic [REG_ADDR_W-1:0]   sec_rd,
    input  logic [XLEN-1:0]         sec_data,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_a3,
    output logic [XLEN-1:0]         rf_wd3,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    drain_req
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned RW = $bits(wb_req_t);

    wb_req_t       push_req;
    wb_req_t       head_req;
    logic [RW-1:0] head_bits;
    logic          prim_live;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_nxt;
    logic          drain_nxt;

    // Writes to x0 are null: they never reach the port or the queue.
    assign prim_live     = wb_valid && (wb_rd != REG_X0);
    assign sec_ready     = !full;
    assign push          = sec_valid && sec_ready && (sec_rd != REG_X0);
    assign pop           = !prim_live && !empty;
    assign push_req.rd   = sec_rd;
    assign push_req.data = sec_data;
    assign head_req      = wb_req_t'(head_bits);
    assign fifo_count    = count;

    wb_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (RW'(push_req)),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next-state view of occupancy and starvation so drain_req lines up with them.
    always_comb begin
        count_nxt  = count + CW'(push) - CW'(pop);
        starve_nxt = starve_q;
        if (pop || empty) begin
            starve_nxt = '0;
        end else if (prim_live && (starve_q < SW'(STARVE_MAX))) begin
            starve_nxt = starve_q + SW'(1);
        end
        drain_nxt = (count_nxt == CW'(DEPTH)) || (starve_nxt == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_a3     <= '0;
            rf_wd3    <= '0;
            starve_q  <= '0;
            drain_req <= 1'b0;
        end else begin
            starve_q  <= starve_nxt;
            drain_req <= drain_nxt;
            if (prim_live) begin
                rf_we  <= 1'b1;
                rf_a3  <= wb_rd;
                rf_wd3 <= wb_data;
            end else if (!empty) begin
                rf_we  <= 1'b1;
                rf_a3  <= head_req.rd;
                rf_wd3 <= head_req.data;
            end else begin
                rf_we  <= 1'b0;
            end
        end
    end

endmodule
